bus_port_fifo: RTL and testbench
================================

# bus_port_fifo

Per-driver port buffer on the shared data bus, one instance per driver. It sits on both sides of the bus generator/arbiter. The TX side queues host packets and presents them to the arbiter as `pndng`/`D_pop`, advancing when the arbiter asserts `pop`. The RX side captures packets the arbiter delivers via `push`/`D_push` into a receive queue that the host drains with a valid/ready handshake.

## Interface
- `width`, 16, packet width in bits; bits [width-1:width-8] are the destination ID; must be ≥ 9
- `depth`, 8, entries per FIFO (TX and RX each); power of two, ≥ 2
- `id`, 0, 8-bit ID of this port
- `broadcast`, 8'hFF, destination ID accepted by every port
- `clk`  input  1  single clock, all state on rising edge
- `reset`  input  1  asynchronous, active-low; asserting (0) clears all state immediately
- `wr_en`  input  1  host write strobe (TX enqueue)
- `wr_data`  input  width  host packet
- `full`  output  1  TX FIFO holds `depth` entries
- `pndng`  output  1  TX FIFO non-empty (to arbiter)
- `D_pop`  output  width  TX head packet, show-ahead (to arbiter)
- `pop`  input  1  arbiter consumes TX head
- `push`  input  1  arbiter delivers a packet
- `D_push`  input  width  delivered packet
- `rx_valid`  output  1  RX FIFO non-empty
- `rx_data`  output  width  RX head packet, show-ahead
- `rx_ready`  input  1  host consumes RX head when `rx_valid`
- `tx_count`  output  $clog2(depth)+1  TX occupancy
- `overflow`  output  1  sticky: a TX write was dropped
- `rx_drop_cnt`  output  8  saturating count of dropped RX packets

## Operation
- Reset values: `full`=0, `pndng`=0, `D_pop`=0, `rx_valid`=0, `rx_data`=0, `tx_count`=0, `overflow`=0, `rx_drop_cnt`=0; pointers are zeroed. Storage contents are don't-care but never visible.
- TX enqueue: `wr_en` with TX not full, or with `pop` accepted in the same cycle, writes `wr_data` at the tail.
- TX full with `wr_en` and no `pop`: the write is dropped, `overflow` sets and holds until reset.
- TX dequeue: `pop` with `pndng`=1 advances the head. `pop` with `pndng`=0 is ignored and has no side effects.
- Simultaneous write and pop: `tx_count` is unchanged. When full, the write is accepted. When empty, the pop is ignored and the write is accepted.
- `D_pop` is driven only from the head entry and is 0 while empty.
- RX accept: `push`=1 and the destination passes the filter (see Configuration) causes an enqueue of `D_push`.
- RX full with an accepted push and no same-cycle dequeue: the packet is dropped and `rx_drop_cnt` increments, saturating at 255.
- RX dequeue: `rx_valid` && `rx_ready`. A packet rejected by the filter is silently ignored and does not count as a drop.
- Pointers are (log2(depth)+1)-bit and wrap modulo 2·depth. Full = MSBs differ and the rest are equal. Empty = all bits equal.

## Timing
- Write to `pndng`: 1 cycle. A write at edge N gives `pndng`=1 and `D_pop`=data after edge N.
- `pop` at edge N: the next head appears on `D_pop` after edge N; `pndng` falls after N if that was the last entry.
- `push` to `rx_valid`: 1 cycle; the same rule applies to `rx_ready`.
- `full`, `pndng`, `rx_valid`, `tx_count` are registered or decoded from registered pointers only; there are no combinational paths from inputs.
- Back-to-back `pop` every cycle is supported at full throughput, as are `push` every cycle and `wr_en` every cycle.
- Reset mid-operation: all outputs go to reset values asynchronously, and queued packets are discarded.

## Configuration
- `BUS_PORT_ADDR_FILTER_EN` defined: an RX push is accepted only when D_push[width-1:width-8] equals `id` or `broadcast`.
- `BUS_PORT_ADDR_FILTER_EN` undefined: every `push` is accepted regardless of destination, and only RX-full drops are counted.

## Structure
- Package `bus_port_pkg` holds:
  - constant `ADDR_W` = 8;
  - default `BROADCAST_ID` = 8'hFF;
  - function `dest_of(pkt)` returning the top `ADDR_W` bits;
  - typedef for the 8-bit port ID.
- Sub-module `bus_port_sync_fifo` (parameters `width`, `depth`) implements the generic show-ahead FIFO with count, full and empty. It is instantiated twice, once for TX and once for RX.
- Top level adds the destination filter, the overflow flag and the drop counter.

## Test plan
- Reset, then write 8 packets 0x0100..0x0107 with no pop → `full`=1, `tx_count`=8, `D_pop`=0x0100. A 9th write → `overflow`=1 and the data is dropped.
- Pop 8 back-to-back → `D_pop` sequence 0x0100..0x0107 then 0, `pndng` falls after the 8th pop. An extra pop has no effect.
- With TX full, write 0x0AAA and pop in the same cycle → `tx_count` stays 8 and 0x0AAA is the last entry out.
- With the filter on and `id`=3: push 0x0311, 0xFF22, 0x0533 → RX holds 0x0311, 0xFF22 and `rx_drop_cnt`=0. With the macro off, all three are held.
- Fill RX with `rx_ready`=0, then push 3 more → `rx_drop_cnt`=3 and contents unchanged. A simultaneous push and `rx_ready` on a full RX is accepted.
- Assert reset with 5 TX and 4 RX entries queued → all outputs are 0 immediately. After release, the first write appears on `D_pop` one cycle later.

Source files
------------

// File: rtl/bus_port_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bus_port_pkg
// Purpose : Shared types, constants and destination decode for bus ports.
// Revision: 1.0 - initial release
// ============================================================================
package bus_port_pkg;

  localparam int ADDR_W    = 8;
  localparam int MAX_PKT_W = 256;

  typedef logic [ADDR_W-1:0] port_id_t;

  localparam port_id_t BROADCAST_ID = 8'hFF;

  // Callers zero-extend the packet to MAX_PKT_W and pass its real width.
  function automatic port_id_t dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                       input int unsigned pkt_w);
    return port_id_t'(pkt >> (pkt_w - ADDR_W));
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_port_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : bus_port_sync_fifo
// Purpose : Show-ahead synchronous FIFO with occupancy count and full flag.
// Revision: 1.0 - initial release
// ============================================================================
module bus_port_sync_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [width-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [width-1:0]         rd_data,
  output logic                     full,
  output logic [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [width-1:0] mem_q [depth];
  logic             empty;
  logic             rd_fire;
  logic             wr_fire;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count   = wr_ptr_q - rd_ptr_q;
    rd_fire = rd_en && !empty;
    // A same-cycle read frees the slot, so a write into a full FIFO still lands.
    wr_fire = wr_en && (!full || rd_fire);
    wr_ptr_d = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_port_fifo.sv
`default_nettype none
// ============================================================================
// Module  : bus_port_fifo
// Purpose : Per-driver TX/RX port buffer between host and bus arbiter.
//           Define BUS_PORT_ADDR_FILTER_EN to accept only packets addressed
//           to this port or to the broadcast ID.
// Revision: 1.0 - initial release
// ============================================================================
module bus_port_fifo
  import bus_port_pkg::*;
#(
  parameter int       width     = 16,
  parameter int       depth     = 8,
  parameter port_id_t id        = 8'd0,
  parameter port_id_t broadcast = BROADCAST_ID
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [width-1:0]       wr_data,
  output logic                   full,
  output logic                   pndng,
  output logic [width-1:0]       D_pop,
  input  logic                   pop,
  input  logic                   push,
  input  logic [width-1:0]       D_push,
  output logic                   rx_valid,
  output logic [width-1:0]       rx_data,
  input  logic                   rx_ready,
  output logic [$clog2(depth):0] tx_count,
  output logic                   overflow,
  output logic [7:0]             rx_drop_cnt
);

`ifdef BUS_PORT_ADDR_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic                   tx_full;
  logic                   rx_full;
  logic [$clog2(depth):0] rx_count;
  logic                   dest_match;
  logic                   rx_accept;
  logic                   rx_drop;
  logic                   overflow_q, overflow_d;
  logic [7:0]             rx_drop_cnt_q, rx_drop_cnt_d;

  bus_port_sync_fifo #(
    .width (width),
    .depth (depth)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (D_pop),
    .full    (tx_full),
    .count   (tx_count)
  );

  bus_port_sync_fifo #(
    .width (width),
    .depth (depth)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_accept),
    .wr_data (D_push),
    .rd_en   (rx_ready),
    .rd_data (rx_data),
    .full    (rx_full),
    .count   (rx_count)
  );

  always_comb begin
    dest_match = (dest_of(MAX_PKT_W'(D_push), width) == id) ||
                 (dest_of(MAX_PKT_W'(D_push), width) == broadcast);
    rx_accept  = push && (!FILTER_EN || dest_match);
    // Full implies non-empty, so rx_ready alone means a slot frees this cycle.
    rx_drop    = rx_accept && rx_full && !rx_ready;
    overflow_d = overflow_q || (wr_en && tx_full && !pop);
    rx_drop_cnt_d = rx_drop_cnt_q;
    if (rx_drop && (rx_drop_cnt_q != 8'hFF)) begin
      rx_drop_cnt_d = rx_drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q    <= 1'b0;
      rx_drop_cnt_q <= 8'd0;
    end else begin
      overflow_q    <= overflow_d;
      rx_drop_cnt_q <= rx_drop_cnt_d;
    end
  end

  assign full        = tx_full;
  assign pndng       = (tx_count != '0);
  assign rx_valid    = (rx_count != '0);
  assign overflow    = overflow_q;
  assign rx_drop_cnt = rx_drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_port_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_port_fifo
// Purpose : Directed self-checking bench for bus_port_fifo (width 16, depth 8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_bus_port_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        full;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop = 1'b0;
  logic        push = 1'b0;
  logic [15:0] D_push = '0;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready = 1'b0;
  logic [3:0]  tx_count;
  logic        overflow;
  logic [7:0]  rx_drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  bus_port_fifo #(
    .width     (16),
    .depth     (8),
    .id        (8'd3),
    .broadcast (8'hFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .pndng       (pndng),
    .D_pop       (D_pop),
    .pop         (pop),
    .push        (push),
    .D_push      (D_push),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .tx_count    (tx_count),
    .overflow    (overflow),
    .rx_drop_cnt (rx_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " full"},     32'(full),        32'd0);
    check({tag, " pndng"},    32'(pndng),       32'd0);
    check({tag, " D_pop"},    32'(D_pop),       32'd0);
    check({tag, " rx_valid"}, 32'(rx_valid),    32'd0);
    check({tag, " rx_data"},  32'(rx_data),     32'd0);
    check({tag, " tx_count"}, 32'(tx_count),    32'd0);
    check({tag, " overflow"}, 32'(overflow),    32'd0);
    check({tag, " rx_drop"},  32'(rx_drop_cnt), 32'd0);
  endtask

  logic [15:0] exp_rx[$];

  initial begin
    // Reset state
    #3;
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Fill TX with 0x0100..0x0107
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 16'h0100 + 16'(i);
      tick();
      if (i == 0) begin
        check("first write pndng", 32'(pndng), 32'd1);
        check("first write D_pop", 32'(D_pop), 32'h0100);
      end
    end
    wr_en = 1'b0;
    check("fill full",     32'(full),     32'd1);
    check("fill tx_count", 32'(tx_count), 32'd8);
    check("fill D_pop",    32'(D_pop),    32'h0100);
    check("fill overflow", 32'(overflow), 32'd0);

    // 9th write is dropped
    wr_en = 1'b1; wr_data = 16'h0999;
    tick();
    wr_en = 1'b0;
    check("ovf flag",     32'(overflow), 32'd1);
    check("ovf tx_count", 32'(tx_count), 32'd8);

    // Back-to-back pops, then one extra on empty
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pop seq", 32'(D_pop), 32'h0100 + 32'(i));
      tick();
    end
    check("drained pndng",    32'(pndng),    32'd0);
    check("drained D_pop",    32'(D_pop),    32'd0);
    check("drained tx_count", 32'(tx_count), 32'd0);
    tick();
    pop = 1'b0;
    check("extra pop count", 32'(tx_count), 32'd0);
    check("extra pop pndng", 32'(pndng),    32'd0);
    check("ovf sticky",      32'(overflow), 32'd1);

    // Write + pop on a full TX
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 16'h0200 + 16'(i);
      tick();
    end
    wr_data = 16'h0AAA; pop = 1'b1;
    tick();
    wr_en = 1'b0;
    check("wr+pop full count", 32'(tx_count), 32'd8);
    check("wr+pop full flag",  32'(full),     32'd1);
    for (int i = 1; i < 8; i++) begin
      check("wr+pop seq", 32'(D_pop), 32'h0200 + 32'(i));
      tick();
    end
    check("wr+pop last", 32'(D_pop), 32'h0AAA);
    tick();
    pop = 1'b0;
    check("wr+pop empty", 32'(pndng), 32'd0);

    // Write + pop on an empty TX: pop ignored, write taken
    wr_en = 1'b1; wr_data = 16'h0BBB; pop = 1'b1;
    tick();
    wr_en = 1'b0; pop = 1'b0;
    check("wr+pop empty count", 32'(tx_count), 32'd1);
    check("wr+pop empty D_pop", 32'(D_pop),    32'h0BBB);
    pop = 1'b1;
    tick();
    pop = 1'b0;

    // RX destination handling
    foreach (exp_rx[k]) exp_rx.delete(k);
    exp_rx.push_back(16'h0311);
    exp_rx.push_back(16'hFF22);
`ifndef BUS_PORT_ADDR_FILTER_EN
    exp_rx.push_back(16'h0533);
`endif
    push = 1'b1;
    D_push = 16'h0311; tick();
    check("rx latency valid", 32'(rx_valid), 32'd1);
    check("rx latency data",  32'(rx_data),  32'h0311);
    D_push = 16'hFF22; tick();
    D_push = 16'h0533; tick();
    push = 1'b0;
    check("rx filter drops", 32'(rx_drop_cnt), 32'd0);
    rx_ready = 1'b1;
    foreach (exp_rx[k]) begin
      check("rx drain data", 32'(rx_data), 32'(exp_rx[k]));
      tick();
    end
    rx_ready = 1'b0;
    check("rx drained valid", 32'(rx_valid), 32'd0);
    check("rx drained data",  32'(rx_data),  32'd0);

    // RX overflow drops and full push+ready
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      D_push = 16'h0340 + 16'(i); tick();
    end
    for (int i = 0; i < 3; i++) begin
      D_push = 16'h03F0 + 16'(i); tick();
    end
    push = 1'b0;
    check("rx drop cnt", 32'(rx_drop_cnt), 32'd3);
    check("rx head kept", 32'(rx_data),    32'h0340);
    push = 1'b1; D_push = 16'h0377; rx_ready = 1'b1;
    tick();
    push = 1'b0;
    check("rx full push+ready cnt", 32'(rx_drop_cnt), 32'd3);
    for (int i = 1; i < 8; i++) begin
      check("rx full seq", 32'(rx_data), 32'h0340 + 32'(i));
      tick();
    end
    check("rx full last", 32'(rx_data), 32'h0377);
    tick();
    rx_ready = 1'b0;
    check("rx empty again", 32'(rx_valid), 32'd0);

    // Saturating drop counter
    push = 1'b1; D_push = 16'h0301;
    for (int i = 0; i < 8 + 260; i++) tick();
    push = 1'b0;
    check("rx drop saturate", 32'(rx_drop_cnt), 32'd255);
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rx_ready = 1'b0;

    // Reset mid-operation with 5 TX and 4 RX queued
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 16'h0500 + 16'(i); tick();
    end
    wr_en = 1'b0;
    check("pre-reset tx_count", 32'(tx_count), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async reset");
    #1;
    reset = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 16'h0C0C;
    tick();
    wr_en = 1'b0;
    check("post-reset D_pop",    32'(D_pop),    32'h0C0C);
    check("post-reset tx_count", 32'(tx_count), 32'd1);
    check("post-reset rx_valid", 32'(rx_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
